// File: rtl/o_feature_writeback_pkg.sv
// Shared definitions for the feature writeback stage: FSM encoding and the
// elements-per-word derivation.
package o_feature_writeback_pkg;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_RUN   = 2'd1,
    WB_DRAIN = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_t;

  localparam int WB_COUNT_WIDTH = 8;

  function automatic int calc_pack(input int data_bus_width, input int in_width);
    return data_bus_width / in_width;
  endfunction

endpackage

// File: rtl/o_feature_writeback_word_fifo.sv
// Synchronous word FIFO with show-ahead head output. A push into a full FIFO
// is only taken when a pop happens at the same edge.
module wb_word_fifo #(
  parameter int WIDTH = 128,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/o_feature_writeback.sv
// Packs the scaled feature stream into bus-width words, buffers them and writes
// them to feature memory over a valid/ready port, one job per start pulse.
module o_feature_writeback
  import o_feature_writeback_pkg::*;
#(
  parameter int IN_WIDTH        = 16,
  parameter int DATA_BUS_WIDTH  = 128,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_enable,
  input  logic [ADDR_WIDTH-1:0]     wb_dst_addr,
  input  logic [7:0]                wb_count,
  input  logic [IN_WIDTH-1:0]       feature_in,
  input  logic                      feature_valid,
  output logic                      in_ready,
  output logic [DATA_BUS_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic                      o_wr_en,
  input  logic                      o_ready,
  output logic                      wb_done,
  output logic                      overflow,
  output logic                      busy
);

  localparam int PACK = calc_pack(DATA_BUS_WIDTH, IN_WIDTH);
  localparam int EW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [EW-1:0] LAST_ELEM = EW'(PACK - 1);

  wb_state_t r_state, w_next_state;

  logic [ADDR_WIDTH-1:0]              r_load_addr;
  logic [7:0]                         r_count;
  logic [7:0]                         r_acc_cnt;
  logic [7:0]                         r_kept_cnt;
  logic [7:0]                         r_wr_cnt;
  logic [EW-1:0]                      r_elem_cnt;
  logic [DATA_BUS_WIDTH-IN_WIDTH-1:0] r_pack;
  logic                               r_overflow;
  logic [DATA_BUS_WIDTH-1:0]          r_o_data;
  logic [ADDR_WIDTH-1:0]              r_o_addr;
  logic                               r_o_wr_en;

  logic                      w_start;
  logic                      w_accept;
  logic                      w_word_done;
  logic                      w_last_word;
  logic                      w_pop;
  logic                      w_write;
  logic                      w_drop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [DATA_BUS_WIDTH-1:0] w_fifo_head;
  logic [DATA_BUS_WIDTH-1:0] w_word;

  assign in_ready    = (r_state == WB_RUN) && (r_acc_cnt < r_count);
  assign w_start     = (r_state == WB_IDLE) && wb_enable;
  assign w_accept    = feature_valid && in_ready;
  assign w_word_done = w_accept && (r_elem_cnt == LAST_ELEM);
  assign w_last_word = w_word_done && (r_acc_cnt == r_count - 8'd1);
  assign w_word      = {feature_in, r_pack};
  // The output register takes a new word whenever it is empty or being drained.
  assign w_pop       = !w_fifo_empty && (!r_o_wr_en || o_ready);
  assign w_write     = r_o_wr_en && o_ready;
  assign w_drop      = w_word_done && w_fifo_full && !w_pop;

  assign o_data   = r_o_data;
  assign o_addr   = r_o_addr;
  assign o_wr_en  = r_o_wr_en;
  assign overflow = r_overflow;
  assign wb_done  = (r_state == WB_DONE);
  assign busy     = (r_state != WB_IDLE);

  wb_word_fifo #(
    .WIDTH (DATA_BUS_WIDTH),
    .AW    (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_word_done),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WB_IDLE:  if (wb_enable) w_next_state = (wb_count == 8'd0) ? WB_DONE : WB_RUN;
      WB_RUN:   if (w_last_word) w_next_state = WB_DRAIN;
      // Dropped words are never written, so completion compares against kept words.
      WB_DRAIN: if (r_wr_cnt == r_kept_cnt) w_next_state = WB_DONE;
      WB_DONE:  w_next_state = WB_IDLE;
      default:  w_next_state = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_acc_cnt  <= '0;
      r_kept_cnt <= '0;
      r_wr_cnt   <= '0;
      r_elem_cnt <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_count    <= wb_count;
      r_acc_cnt  <= '0;
      r_kept_cnt <= '0;
      r_wr_cnt   <= '0;
      r_elem_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_word_done) begin
        r_elem_cnt <= '0;
        r_acc_cnt  <= r_acc_cnt + 8'd1;
        if (w_drop) r_overflow <= 1'b1;
        else        r_kept_cnt <= r_kept_cnt + 8'd1;
      end else if (w_accept) begin
        r_elem_cnt <= r_elem_cnt + EW'(1);
        for (int s = 0; s < PACK - 1; s++) begin
          if (r_elem_cnt == EW'(s)) r_pack[s*IN_WIDTH +: IN_WIDTH] <= feature_in;
        end
      end
      if (w_write) r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_addr <= '0;
      r_o_data    <= '0;
      r_o_addr    <= '0;
      r_o_wr_en   <= 1'b0;
    end else begin
      if (w_start) r_load_addr <= wb_dst_addr;
      else if (w_pop) r_load_addr <= r_load_addr + ADDR_WIDTH'(1);
      if (w_pop) begin
        r_o_wr_en <= 1'b1;
        r_o_data  <= w_fifo_head;
        r_o_addr  <= r_load_addr;
      end else if (w_write) begin
        r_o_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_o_feature_writeback.sv
// Bench for o_feature_writeback: a word-level reference model fills an expected
// queue per job and an independent monitor checks every accepted write.
module tb_o_feature_writeback;

  localparam int IW = 16;
  localparam int DW = 128;
  localparam int PK = DW / IW;
  localparam int AW = 16;
  localparam int EXP_W = AW + DW;
  localparam int CAPACITY = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_enable;
  logic [AW-1:0] wb_dst_addr;
  logic [7:0]    wb_count;
  logic [IW-1:0] feature_in;
  logic          feature_valid;
  logic          in_ready;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic          o_wr_en;
  logic          o_ready;
  logic          wb_done;
  logic          overflow;
  logic          busy;

  o_feature_writeback #(
    .IN_WIDTH        (IW),
    .DATA_BUS_WIDTH  (DW),
    .FIFO_ADDR_WIDTH (3),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_enable     (wb_enable),
    .wb_dst_addr   (wb_dst_addr),
    .wb_count      (wb_count),
    .feature_in    (feature_in),
    .feature_valid (feature_valid),
    .in_ready      (in_ready),
    .o_data        (o_data),
    .o_addr        (o_addr),
    .o_wr_en       (o_wr_en),
    .o_ready       (o_ready),
    .wb_done       (wb_done),
    .overflow      (overflow),
    .busy          (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_e;
  logic [IW-1:0]    elems[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int ready_mode = 0;
  int bp_left = 0;

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic          prev_done  = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", EXP_W'(o_wr_en), EXP_W'(1));
        check("hold_data", EXP_W'(o_data), EXP_W'(prev_data));
        check("hold_addr", EXP_W'(o_addr), EXP_W'(prev_addr));
      end
      if (o_wr_en && o_ready) begin
        n_writes++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got write addr %0h data %0h, expected no write", o_addr, o_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", EXP_W'(o_addr), EXP_W'(exp_e[EXP_W-1:DW]));
          check("wr_data", EXP_W'(o_data), EXP_W'(exp_e[DW-1:0]));
        end
      end
      if (wb_done) begin
        if (prev_done) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_width: got wb_done high 2 cycles, expected 1");
        end
        done_seen++;
        done_cyc = cyc;
      end
      prev_stall = o_wr_en && !o_ready;
      prev_data  = o_data;
      prev_addr  = o_addr;
      prev_done  = wb_done;
    end
  end

  // ---------------- memory-side ready driver ----------------
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: o_ready = 1'b1;
        1: o_ready = 1'b0;
        2: o_ready = ($urandom_range(0, 99) < 60);
        default: begin
          if (o_wr_en && bp_left > 0) begin
            o_ready = 1'b0;
            bp_left--;
          end else begin
            o_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word i holds elements i*PK..i*PK+PK-1 LSB-first and goes
  // to base+i; only the first 'kept' words ever reach memory.
  task automatic plan_job(input logic [AW-1:0] base, input int count, input int kept, input bit seq);
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    elems.delete();
    for (int i = 0; i < count * PK; i++)
      elems.push_back(seq ? IW'(i + 1) : IW'($urandom));
    for (int i = 0; i < kept; i++) begin
      for (int j = 0; j < PK; j++) w[j*IW +: IW] = elems[i*PK + j];
      a = base + AW'(i);
      exp_q.push_back({a, w});
    end
  endtask

  task automatic start_job(input logic [AW-1:0] a, input logic [7:0] c);
    wb_dst_addr = a;
    wb_count    = c;
    wb_enable   = 1'b1;
    tick();
    wb_enable   = 1'b0;
  endtask

  task automatic send_elems(input int pct);
    int idx = 0;
    while (idx < elems.size()) begin
      if ($urandom_range(0, 99) < pct) begin
        feature_valid = 1'b1;
        feature_in    = elems[idx];
        check("in_ready_on", EXP_W'(in_ready), EXP_W'(1));
        idx++;
      end else begin
        feature_valid = 1'b0;
        feature_in    = IW'($urandom);
      end
      tick();
    end
    feature_valid = 1'b0;
    check("in_ready_off", EXP_W'(in_ready), EXP_W'(0));
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_seen == d0 && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", EXP_W'(done_seen != d0), EXP_W'(1));
    tick();
    check("queue_drained", EXP_W'(exp_q.size()), EXP_W'(0));
    check("busy_idle", EXP_W'(busy), EXP_W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int w0;
    logic [AW-1:0] ra;
    int rc;
    rst = 1'b1;
    wb_enable = 1'b0;
    wb_dst_addr = '0;
    wb_count = '0;
    feature_in = '0;
    feature_valid = 1'b0;
    tick();
    check("rst_wr_en", EXP_W'(o_wr_en), EXP_W'(0));
    check("rst_data", EXP_W'(o_data), EXP_W'(0));
    check("rst_addr", EXP_W'(o_addr), EXP_W'(0));
    check("rst_in_ready", EXP_W'(in_ready), EXP_W'(0));
    check("rst_done", EXP_W'(wb_done), EXP_W'(0));
    check("rst_overflow", EXP_W'(overflow), EXP_W'(0));
    check("rst_busy", EXP_W'(busy), EXP_W'(0));
    tick();
    rst = 1'b0;
    tick();

    // Basic job: sequential elements, memory always ready.
    ready_mode = 0;
    d0 = done_seen;
    plan_job(16'h0100, 2, 2, 1'b1);
    start_job(16'h0100, 8'd2);
    check("busy_run", EXP_W'(busy), EXP_W'(1));
    send_elems(100);
    wait_done(d0, 50);
    check("done_after_write", EXP_W'(done_cyc > last_wr_cyc), EXP_W'(1));
    check("done_soon", EXP_W'(done_cyc - last_wr_cyc <= 3), EXP_W'(1));

    // Backpressure after the first write request.
    ready_mode = 3;
    bp_left = 5;
    d0 = done_seen;
    plan_job(16'h0100, 2, 2, 1'b1);
    start_job(16'h0100, 8'd2);
    send_elems(100);
    wait_done(d0, 80);
    check("done_after_bp_write", EXP_W'(done_cyc > last_wr_cyc), EXP_W'(1));

    // Overflow: no memory ready during input, 10 words into 9 slots.
    ready_mode = 1;
    d0 = done_seen;
    w0 = n_writes;
    plan_job(16'h0500, 10, CAPACITY, 1'b0);
    start_job(16'h0500, 8'd10);
    send_elems(100);
    check("overflow_set", EXP_W'(overflow), EXP_W'(1));
    check("no_write_stalled", EXP_W'(n_writes - w0), EXP_W'(0));
    ready_mode = 0;
    wait_done(d0, 200);
    check("overflow_writes", EXP_W'(n_writes - w0), EXP_W'(CAPACITY));
    check("overflow_sticky", EXP_W'(overflow), EXP_W'(1));

    // Address wrap; the new job clears overflow.
    d0 = done_seen;
    plan_job(16'hFFFF, 2, 2, 1'b0);
    start_job(16'hFFFF, 8'd2);
    check("overflow_cleared", EXP_W'(overflow), EXP_W'(0));
    send_elems(70);
    wait_done(d0, 50);

    // Zero-length job.
    d0 = done_seen;
    w0 = n_writes;
    start_job(16'h0A00, 8'd0);
    wait_done(d0, 4);
    check("zero_no_write", EXP_W'(n_writes - w0), EXP_W'(0));

    // Ignored wb_enable during RUN and surplus elements after the last word.
    d0 = done_seen;
    w0 = n_writes;
    plan_job(16'h0400, 3, 3, 1'b0);
    start_job(16'h0400, 8'd3);
    wb_dst_addr = 16'h5555;
    wb_count = 8'd1;
    wb_enable = 1'b1;
    tick();
    wb_enable = 1'b0;
    send_elems(100);
    for (int i = 0; i < 12; i++) begin
      feature_valid = 1'b1;
      feature_in = IW'($urandom);
      tick();
    end
    feature_valid = 1'b0;
    wait_done(d0, 60);
    check("ignored_writes", EXP_W'(n_writes - w0), EXP_W'(3));

    // Randomized jobs with random memory backpressure.
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      ra = AW'($urandom);
      rc = $urandom_range(1, 5);
      d0 = done_seen;
      plan_job(ra, rc, rc, 1'b0);
      start_job(ra, 8'(rc));
      send_elems($urandom_range(30, 100));
      wait_done(d0, 300);
      check("rand_no_overflow", EXP_W'(overflow), EXP_W'(0));
    end

    // Asynchronous reset in the middle of a job, then a clean job.
    ready_mode = 0;
    start_job(16'h0300, 8'd1);
    for (int i = 0; i < 3; i++) begin
      feature_valid = 1'b1;
      feature_in = IW'($urandom);
      tick();
    end
    feature_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_en", EXP_W'(o_wr_en), EXP_W'(0));
    check("arst_data", EXP_W'(o_data), EXP_W'(0));
    check("arst_addr", EXP_W'(o_addr), EXP_W'(0));
    check("arst_in_ready", EXP_W'(in_ready), EXP_W'(0));
    check("arst_busy", EXP_W'(busy), EXP_W'(0));
    check("arst_done", EXP_W'(wb_done), EXP_W'(0));
    check("arst_overflow", EXP_W'(overflow), EXP_W'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    d0 = done_seen;
    plan_job(16'h0200, 1, 1, 1'b1);
    start_job(16'h0200, 8'd1);
    send_elems(100);
    wait_done(d0, 50);

    check("final_queue_empty", EXP_W'(exp_q.size()), EXP_W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
